// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch (I) requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    // Data (D) requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    // Unified memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Pipeline plus memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port memory; ARB_PERF_CNT_EN adds grant/conflict counters
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_conf_cnt
`endif
);
    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam int STV_W = $clog2(STARVE_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;     // 0 = fetch, 1 = data
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic d_wins;
    logic grant_i;
    logic grant_d;

    // Data has priority unless fetch has been passed over STARVE_MAX times in a row
    assign d_wins  = bus.d_req && !(bus.i_req && (starve_q == STARVE_TOP));
    assign grant_d = (state_q == ST_IDLE) && d_wins;
    assign grant_i = (state_q == ST_IDLE) && !d_wins && bus.i_req;

    // State and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Arbitration, access sequencing and read-data capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    owner_d     = 1'b1;
                    mem_addr_d  = bus.d_addr;
                    mem_we_d    = bus.d_we;
                    mem_wdata_d = bus.d_wdata;
                    cnt_d       = CNT_INIT;
                    state_d     = ST_BUSY;
                    if (!bus.i_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_TOP) begin
                        starve_d = starve_q + STV_W'(1);
                    end
                end else if (grant_i) begin
                    owner_d     = 1'b0;
                    mem_addr_d  = bus.i_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    cnt_d       = CNT_INIT;
                    state_d     = ST_BUSY;
                    starve_d    = '0;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (!owner_q) begin
                        i_rdata_d = bus.mem_rdata;
                    end else if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Requester's req is still high here; it is deliberately not re-arbitrated
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_en    = (state_q == ST_BUSY);
    assign bus.mem_we    = mem_we_q && (state_q == ST_BUSY);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = (state_q == ST_DONE) && !owner_q;
    assign bus.d_ready   = (state_q == ST_DONE) && owner_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_conf_q, perf_conf_d;

    assign perf_i_d    = perf_i_q + {31'd0, grant_i};
    assign perf_d_d    = perf_d_q + {31'd0, grant_d};
    assign perf_conf_d = perf_conf_q + {31'd0, (state_q == ST_IDLE) && bus.i_req && bus.d_req};

    // Free-running wrap-around grant and conflict counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_i_q    <= '0;
            perf_d_q    <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_i_q    <= perf_i_d;
            perf_d_q    <= perf_d_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_i_cnt    = perf_i_q;
    assign perf_d_cnt    = perf_d_q;
    assign perf_conf_cnt = perf_conf_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_cnt;
    logic [31:0] perf_d_cnt;
    logic [31:0] perf_conf_cnt;
`endif

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_i_cnt   (perf_i_cnt),
        .perf_d_cnt   (perf_d_cnt),
        .perf_conf_cnt(perf_conf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'hE3A00001;
        return 32'h5A000000 ^ (32'(i) * 32'h00010203);
    endfunction

    // Environment memory: read data is only valid in the last access cycle
    logic [31:0] env_mem [64];
    int          seen = 0;
    assign bus.mem_rdata = (bus.mem_en && seen == MEM_LAT) ? env_mem[bus.mem_addr[7:2]] : 32'hBAD0BAD0;

    always @(negedge clk) begin
        if (bus.mem_en) begin
            seen = seen + 1;
            if (bus.mem_we) env_mem[bus.mem_addr[7:2]] = bus.mem_wdata;
        end else begin
            seen = 0;
        end
    end

    // Reference model: one access at a time, free again MEM_LAT+2 edges after a grant
    typedef struct {
        int          cyc;
        bit          port;
        logic [31:0] data;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] ref_mem [64];
    int          cyc     = 0;
    int          free_at = 0;
    int          starve  = 0;
    int          busy_lo = -1;
    int          busy_hi = -2;
    logic [31:0] cur_addr  = '0;
    logic [31:0] cur_wdata = '0;
    bit          cur_we    = 0;
    logic [31:0] mdl_d_hold = '0;
    bit          take_d, take_i;
    exp_t        ne;

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            expq.delete();
            free_at    = 0;
            starve     = 0;
            busy_lo    = -1;
            busy_hi    = -2;
            mdl_d_hold = '0;
        end else if (cyc >= free_at) begin
            take_d = bus.d_req && !(bus.i_req && starve == STARVE_MAX);
            take_i = !take_d && bus.i_req;
            if (take_d || take_i) begin
                busy_lo = cyc;
                busy_hi = cyc + MEM_LAT - 1;
                free_at = cyc + MEM_LAT + 2;
                ne.cyc  = cyc + MEM_LAT;
                ne.port = take_d;
                if (take_d) begin
                    cur_addr  = bus.d_addr;
                    cur_we    = bus.d_we;
                    cur_wdata = bus.d_wdata;
                    starve    = bus.i_req ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
                    if (cur_we) begin
                        ref_mem[cur_addr[7:2]] = cur_wdata;
                    end else begin
                        mdl_d_hold = ref_mem[cur_addr[7:2]];
                    end
                    ne.data = mdl_d_hold;
                end else begin
                    cur_addr = bus.i_addr;
                    cur_we   = 0;
                    starve   = 0;
                    ne.data  = ref_mem[cur_addr[7:2]];
                end
                expq.push_back(ne);
            end
        end
    end

    // Monitor: compares every cycle's outputs against the model
    logic [31:0] mon_i_hold = '0;
    logic [31:0] mon_d_hold = '0;
    bit          exp_en;
    exp_t        me;

    always @(negedge clk) begin
        if (!reset) begin
            mon_i_hold = '0;
            mon_d_hold = '0;
        end
        exp_en = reset && (cyc >= busy_lo) && (cyc <= busy_hi);
        chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
        if (exp_en) begin
            chk("mem_addr", bus.mem_addr, cur_addr);
            chk("mem_we", 32'(bus.mem_we), 32'(cur_we));
            if (cur_we) chk("mem_wdata", bus.mem_wdata, cur_wdata);
        end
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            me = expq.pop_front();
            chk("i_ready", 32'(bus.i_ready), 32'(!me.port));
            chk("d_ready", 32'(bus.d_ready), 32'(me.port));
            if (me.port) mon_d_hold = me.data;
            else         mon_i_hold = me.data;
        end else begin
            chk("i_ready_idle", 32'(bus.i_ready), 32'd0);
            chk("d_ready_idle", 32'(bus.d_ready), 32'd0);
        end
        chk("i_rdata", bus.i_rdata, mon_i_hold);
        chk("d_rdata", bus.d_rdata, mon_d_hold);
    end

    // Stimulus helpers
    task automatic wait_ready(input bit port, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? bus.d_ready : bus.i_ready) && n < limit);
        checks++;
        if (!(port ? bus.d_ready : bus.i_ready)) begin
            failures++;
            $display("FAIL wait_ready port=%0d actual=timeout required=ready", port);
        end else if (port) begin
            bus.d_req = 1'b0;
        end else begin
            bus.i_req = 1'b0;
        end
    endtask

    task automatic tick(input int p_i, input int p_d);
        @(negedge clk);
        if (bus.i_req && bus.i_ready) bus.i_req = 1'b0;
        if (bus.d_req && bus.d_ready) bus.d_req = 1'b0;
        if (!bus.i_req && $urandom_range(99) < p_i) begin
            bus.i_req  = 1'b1;
            bus.i_addr = 32'($urandom_range(63)) << 2;
        end
        if (!bus.d_req && $urandom_range(99) < p_d) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom_range(1));
            bus.d_addr  = 32'($urandom_range(63)) << 2;
            bus.d_wdata = $urandom;
        end
    endtask

    int  n;
    int  nd;
    bit  got_i;
    bit  got_en;

    initial begin
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        reset       = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mem_addr", bus.mem_addr, 32'd0);
        chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Simultaneous requests: D first, then I once d_req is dropped
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h44;
        wait_ready(1'b1, 20, n);
        chk("conflict_d_latency", 32'(n), 32'(MEM_LAT + 1));
        chk("conflict_i_waiting", 32'(bus.i_ready), 32'd0);
        wait_ready(1'b0, 20, n);
        chk("conflict_i_after_d", 32'(n), 32'(MEM_LAT + 2));
`ifdef ARB_PERF_CNT_EN
        chk("perf_i_cnt", perf_i_cnt, 32'd1);
        chk("perf_d_cnt", perf_d_cnt, 32'd1);
        chk("perf_conf_cnt", perf_conf_cnt, 32'd1);
`endif
        @(negedge clk);

        // Fetch only from 0x100
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        wait_ready(1'b0, 20, n);
        chk("ifetch_latency", 32'(n), 32'(MEM_LAT + 1));
        chk("ifetch_data", bus.i_rdata, 32'hE3A00001);
        @(negedge clk);

        // Data write leaves d_rdata at the earlier read of 0x44
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h20;
        bus.d_wdata = 32'hDEADBEEF;
        wait_ready(1'b1, 20, n);
        chk("dwrite_latency", 32'(n), 32'(MEM_LAT + 1));
        chk("dwrite_rdata_kept", bus.d_rdata, init_val(17));
        @(negedge clk);

        // Starvation: D continuously re-issued while I waits
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h80;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h84;
        nd    = 0;
        got_i = 0;
        for (int k = 0; k < 80 && !got_i; k++) begin
            @(negedge clk);
            if (bus.i_ready) begin
                got_i     = 1;
                bus.i_req = 1'b0;
            end
            if (bus.d_ready) begin
                nd++;
                bus.d_addr = 32'($urandom_range(63)) << 2;
            end
        end
        chk("starve_i_granted", 32'(got_i), 32'd1);
        chk("starve_d_grants", 32'(nd), 32'(STARVE_MAX));
        wait_ready(1'b1, 20, n);
        chk("starve_d_resumes", 32'(n), 32'(MEM_LAT + 2));
        @(negedge clk);

        // Randomized traffic, light then heavy contention
        repeat (2500) tick(30, 30);
        repeat (1500) tick(90, 95);
        repeat (30) tick(0, 0);

        // Reset in the middle of a fetch
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0C;
        got_en = 0;
        for (int k = 0; k < 20 && !got_en; k++) begin
            @(negedge clk);
            got_en = bus.mem_en;
        end
        chk("rst_saw_busy", 32'(got_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_i_rdata", bus.i_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_ready(1'b0, 20, n);
        chk("rst_rearbitrate", 32'(n), 32'(MEM_LAT + 1));
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single shared single-port memory between the pipeline's instruction-fetch requester (I) and data-memory requester (D).
- Sits between the ARM pipeline top and a unified memory.
- Produces per-port ready handshakes that the hazard unit turns into StallF/StallM.
- Data has priority, with an anti-starvation guarantee for fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles the memory needs per access (>=1); BUSY state length.
- STARVE_MAX, 4, max consecutive D grants while i_req is pending before I is forced.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high with i_addr stable until i_ready.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data; valid while i_ready=1, held until next I completion.
- i_ready  out  1  one-cycle completion pulse for I.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data; valid while d_ready=1, held until next D read completion.
- d_ready  out  1  one-cycle completion pulse for D.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last BUSY cycle.

Behaviour:
- Reset (reset=0, async): state=IDLE; cnt=0; starve=0; all outputs 0 (i_rdata, d_rdata, mem_addr, mem_wdata included). An in-flight access is abandoned and its ready pulse is never produced; requesters re-issue.
- FSM states: IDLE, BUSY, DONE. Registered owner bit: 0=I, 1=D.
- IDLE, arbitration:
  - D wins if d_req, unless i_req && starve==STARVE_MAX, in which case I wins.
  - Otherwise I wins if i_req.
  - On a grant: latch addr/we/wdata into mem_addr/mem_we/mem_wdata; mem_we=0 for I; set owner; cnt<=MEM_LAT-1; go to BUSY.
- starve counter:
  - Increments (saturating at STARVE_MAX) on each D grant made while i_req=1.
  - Clears on any I grant, or on a D grant while i_req=0.
- BUSY:
  - mem_en=1 for every BUSY cycle; mem_addr/mem_we/mem_wdata held stable.
  - cnt decrements each cycle.
  - When cnt==0: on that edge, capture mem_rdata into the owner's rdata register (reads only; D writes leave d_rdata unchanged); go to DONE.
- DONE:
  - Owner's ready=1 for exactly this cycle; mem_en=0, mem_we=0.
  - The requester's still-high req is ignored this cycle (no re-issue).
  - Go to IDLE.
- Timing:
  - Latency from req sampled in IDLE to ready is MEM_LAT+1 cycles.
  - Minimum issue spacing is MEM_LAT+2 cycles.
  - Exactly one access is outstanding at a time.
- Simultaneous i_req and d_req in IDLE: D is granted; I waits (i_ready=0) and is serviced next unless d_req is re-asserted, subject to the starve rule.
- A req deasserted while not yet granted is dropped silently.
- Deasserting req mid-BUSY is a protocol violation; the access still completes.
- i_ready and d_ready are never high in the same cycle.
- Widths: cnt is clog2(MEM_LAT)+1 bits; starve is clog2(STARVE_MAX)+1 bits.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_i_cnt[31:0] (I grants), perf_d_cnt[31:0] (D grants) and perf_conf_cnt[31:0] (IDLE cycles with i_req && d_req both high).
  - All three wrap at 2^32 and are cleared by reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- I only, MEM_LAT=2, i_addr=0x100, mem returns 0xE3A00001 -> mem_en high 2 cycles with mem_addr=0x100, mem_we=0; i_ready pulses 1 cycle, 3 cycles after req; i_rdata=0xE3A00001.
- D write, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF for 2 cycles; d_ready pulse; d_rdata unchanged.
- i_req and d_req asserted in the same cycle -> D granted first; I granted in the IDLE cycle after d_ready, provided d_req is low.
- d_req held continuously (re-issued after each d_ready) with i_req high, STARVE_MAX=4 -> 4 D grants, then I granted; starve cleared; D resumes.
- reset driven low mid-BUSY -> mem_en=0 immediately; no ready pulse; after reset release the same req re-arbitrates from IDLE.
- ARB_PERF_CNT_EN defined, scenario 3 run once -> perf_i_cnt=1, perf_d_cnt=1, perf_conf_cnt=1.
